// File: rtl/mips_instr_fetch_if.sv
// mips_instr_fetch_if: bundle between the fetch sequencer and its environment
// (decoder, instruction memory, pipeline control).
//   master : the fetch unit (drives PC, gated instruction, link, status)
//   slave  : the environment (drives enables, redirect request, read data)
interface mips_instr_fetch_if;
    logic        clk_enable;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_readdata;
    logic [31:0] instr_address;
    logic [31:0] instr_word;
    logic [31:0] link_address;
    logic        in_delay_slot;
    logic        active;
    logic [31:0] retired_count;
    logic        fetch_fault;

    modport master (
        input  clk_enable, stall, redirect_valid, redirect_target, instr_readdata,
        output instr_address, instr_word, link_address, in_delay_slot, active,
               retired_count, fetch_fault
    );

    modport slave (
        output clk_enable, stall, redirect_valid, redirect_target, instr_readdata,
        input  instr_address, instr_word, link_address, in_delay_slot, active,
               retired_count, fetch_fault
    );
endinterface

// File: rtl/mips_instr_fetch.sv
// mips_instr_fetch: PC / instruction-fetch sequencer with MIPS branch delay slot.
//   clk, reset (async, active-high) : plain ports
//   bus (mips_instr_fetch_if.master): enables, redirect request, instruction
//                                     memory port, link address, status
// States: RUN (sequential), DELAY (executing delay slot, target pending),
// HALT (fetched HALT_ADDRESS or faulted; left only by reset).
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- a misaligned captured redirect
// target raises fetch_fault and halts instead of being silently word-aligned.
module mips_instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset,
    mips_instr_fetch_if.master bus
);
    typedef enum logic [1:0] {S_RUN, S_DELAY, S_HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        active_q, active_d;
    logic [31:0] count_q, count_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fault_q, fault_d;
`endif

    logic        advance;
    logic        load_pc;
    logic [31:0] next_pc;

    assign advance = bus.clk_enable & ~bus.stall & (state_q != S_HALT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        active_d  = active_q;
        count_d   = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d   = fault_q;
`endif
        next_pc   = pc_q + 32'd4;
        load_pc   = 1'b0;

        if (advance) begin
            count_d = count_q + 32'd1;
            load_pc = 1'b1;
            case (state_q)
                S_RUN: begin
                    // The branch itself completes; the delay slot is next.
                    if (bus.redirect_valid) begin
                        state_d = S_DELAY;
`ifdef FETCH_ALIGN_CHECK_EN
                        pending_d = bus.redirect_target;
`else
                        pending_d = bus.redirect_target & 32'hFFFF_FFFC;
`endif
                    end
                end
                S_DELAY: begin
                    // A redirect raised by the delay-slot instruction is dropped.
                    next_pc = pending_q;
                    state_d = S_RUN;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pending_q[1:0] != 2'b00) begin
                        load_pc  = 1'b0;
                        fault_d  = 1'b1;
                        state_d  = S_HALT;
                        active_d = 1'b0;
                    end
`endif
                end
                default: load_pc = 1'b0;
            endcase

            // Halting wins over a pending delay slot: the halt address is final.
            if (load_pc) begin
                pc_d = next_pc;
                if (next_pc == HALT_ADDRESS) begin
                    state_d  = S_HALT;
                    active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RUN;
            pc_q      <= RESET_VECTOR;
            pending_q <= 32'h0;
            active_q  <= 1'b1;
            count_q   <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            count_q   <= count_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q   <= fault_d;
`endif
        end
    end

    assign bus.instr_address = pc_q;
    assign bus.instr_word    = (state_q != S_HALT) ? bus.instr_readdata : 32'h0;
    assign bus.link_address  = pc_q + 32'd8;
    assign bus.in_delay_slot = (state_q == S_DELAY);
    assign bus.active        = active_q;
    assign bus.retired_count = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fetch_fault   = fault_q;
`else
    assign bus.fetch_fault   = 1'b0;
`endif
endmodule
